// File: rtl/set_resp_router_pkg.sv
// Shared definitions for the set response return path.
package set_resp_router_pkg;

  localparam int SET_W_DEF = 9;
  localparam int SRC_W_DEF = 1;

  // Response beat as it leaves the cache pipeline.
  typedef struct packed {
    logic [SET_W_DEF-1:0] set;
    logic [SRC_W_DEF-1:0] source;
  } resp_t;

  // Ceiling log2 for sizing pointers and counters (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/set_resp_fifo.sv
// Per-requester response FIFO: DEPTH x SET_W, storage cleared on reset.
module set_resp_fifo
  import set_resp_router_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SET_W = SET_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  input  logic [SET_W-1:0] enq_set,
  output logic             full,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [SET_W-1:0] deq_set
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SET_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             enq_fire;
  logic             deq_fire;

  assign full      = (count == CW'(DEPTH));
  assign deq_valid = (count != '0);
  assign deq_set   = mem[rptr];
  // Full blocks enqueue even if the head leaves this cycle; keeps ready off the out_ready path.
  assign enq_fire  = enq_valid & ~full;
  assign deq_fire  = deq_valid & deq_ready;

  // Storage write; cleared on reset so outputs read zero afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (enq_fire) begin
      mem[wptr] <= enq_set;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + 1'b1;
      if (deq_fire) rptr <= rptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Occupancy must stay within 0..DEPTH.
  a_count_range: assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(deq_fire && count == '0));

endmodule

// File: rtl/set_resp_router.sv
// Demultiplexes one response stream to per-requester FIFOs by source id.
module set_resp_router
  import set_resp_router_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int SRC_W = SRC_W_DEF,
  parameter int DEPTH = 2,
  parameter int SET_W = SET_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [SET_W-1:0]       io_in_bits_set,
  input  logic [SRC_W-1:0]       io_in_bits_source,
  output logic [N_OUT-1:0]       io_out_valid,
  input  logic [N_OUT-1:0]       io_out_ready,
  output logic [N_OUT*SET_W-1:0] io_out_bits_set,
  output logic                   io_drop
);

  logic [N_OUT-1:0] sel;
  logic [N_OUT-1:0] full;
  logic             legal;

  // One-hot decode of the destination; an out-of-range id selects nothing.
  always_comb begin
    sel = '0;
    for (int p = 0; p < N_OUT; p++) begin
      sel[p] = (io_in_bits_source == SRC_W'(p));
    end
  end

  assign legal = |sel;
  // Ready depends only on registered fullness of the addressed port; illegal ids always accepted.
  assign io_in_ready = ~|(sel & full);

  // Pulse one cycle after an illegal-source response is accepted and discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) io_drop <= 1'b0;
    else       io_drop <= io_in_valid & ~legal;
  end

  for (genvar p = 0; p < N_OUT; p++) begin : g_port
    set_resp_fifo #(
      .DEPTH (DEPTH),
      .SET_W (SET_W)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (io_in_valid & sel[p]),
      .enq_set   (io_in_bits_set),
      .full      (full[p]),
      .deq_valid (io_out_valid[p]),
      .deq_ready (io_out_ready[p]),
      .deq_set   (io_out_bits_set[p*SET_W +: SET_W])
    );
  end

endmodule
